control_seq: RTL

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq_if.sv | 33 +++
 rtl/control_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/control_seq_if.sv
// control_seq_if: bundles the sequencer's ROM, flag and datapath-control
// signals so the sequencer and its datapath connect through one port.
//   instr         16b  ROM data at address pc (combinational read)
//   z_in, n_in     1b  ALU zero / negative flags for the current operands
//   pc             8b  program counter / ROM address
//   im             8b  immediate operand for the B-operand mux
//   sel_b          2b  B mux select: 00 reg B, 01 zero, 10 immediate
//   alu_op         3b  ALU operation code
//   la, lb         1b  load enables for registers A and B
//   halted         1b  high while the sequencer is stopped
// master = sequencer side, slave = ROM/datapath side.
interface control_seq_if;
  logic [15:0] instr;
  logic        z_in;
  logic        n_in;
  logic [7:0]  pc;
  logic [7:0]  im;
  logic [1:0]  sel_b;
  logic [2:0]  alu_op;
  logic        la;
  logic        lb;
  logic        halted;

  modport master (
    input  instr, z_in, n_in,
    output pc, im, sel_b, alu_op, la, lb, halted
  );

  modport slave (
    output instr, z_in, n_in,
    input  pc, im, sel_b, alu_op, la, lb, halted
  );
endinterface

// File: rtl/control_seq.sv
// control_seq: two-cycle FETCH/EXEC instruction sequencer with a sticky HALT.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   control_seq_if.master (instr/z_in/n_in in; pc/im/sel_b/alu_op/
//         la/lb/halted out)
// Instruction: [15:14] class (00 ALU regB, 01 ALU imm, 10 jump, 11 halt),
// [13:11] alu_op, [10:9] dest (bit9 = A, bit10 = B), [13:12] jump cond,
// [7:0] immediate / jump target.
module control_seq (
  input  logic          clk,
  input  logic          rst,
  control_seq_if.master bus
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

  state_e      state_q;
  logic [15:0] ir_q;
  logic [7:0]  pc_q;
  logic        z_q, n_q;
  logic [1:0]  sel_b_q;
  logic [2:0]  alu_op_q;
  logic        la_q, lb_q, halted_q;

  logic [7:0]  pc_inc;
  logic        take_jmp;
  logic [7:0]  jmp_pc_d;
  logic        unused_ir;

  // Jump resolution uses the registered flags of the last ALU instruction.
  always_comb begin
    pc_inc   = pc_q + 8'd1;
    take_jmp = 1'b0;
    unique case (ir_q[13:12])
      2'b00: take_jmp = 1'b1;
      2'b01: take_jmp = z_q;
      2'b10: take_jmp = ~z_q;
      2'b11: take_jmp = n_q;
    endcase
    jmp_pc_d = take_jmp ? ir_q[7:0] : pc_inc;
  end

  assign unused_ir = ir_q[8];

  // Outputs are registered: during FETCH the EXEC-cycle controls are decoded
  // from instr as it is latched, so they appear together with ir.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= 8'h00;
      ir_q     <= 16'h0000;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      sel_b_q  <= 2'b01;
      alu_op_q <= 3'b000;
      la_q     <= 1'b0;
      lb_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          ir_q    <= bus.instr;
          state_q <= EXEC;
          if (!bus.instr[15]) begin
            alu_op_q <= bus.instr[13:11];
            sel_b_q  <= bus.instr[14] ? 2'b10 : 2'b00;
            la_q     <= bus.instr[9];
            lb_q     <= bus.instr[10];
          end else begin
            alu_op_q <= 3'b000;
            sel_b_q  <= 2'b01;
            la_q     <= 1'b0;
            lb_q     <= 1'b0;
          end
        end
        EXEC: begin
          alu_op_q <= 3'b000;
          sel_b_q  <= 2'b01;
          la_q     <= 1'b0;
          lb_q     <= 1'b0;
          unique case (ir_q[15:14])
            2'b00, 2'b01: begin
              z_q     <= bus.z_in;
              n_q     <= bus.n_in;
              pc_q    <= pc_inc;
              state_q <= FETCH;
            end
            2'b10: begin
              pc_q    <= jmp_pc_d;
              state_q <= FETCH;
            end
            2'b11: begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end
          endcase
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.pc     = pc_q;
  assign bus.im     = ir_q[7:0];
  assign bus.sel_b  = sel_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.la     = la_q;
  assign bus.lb     = lb_q;
  assign bus.halted = halted_q;
endmodule
